seg7_display_arbiter: RTL
=========================

Name: seg7_display_arbiter

Overview:
- Time-shares the single 4-digit seven-segment display (12-bit binary `num` input of the display driver) between NREQ requesters.
- Round-robin arbitration. Each grant holds the display for a fixed dwell window, followed by a blanking gap.
- Sits between status sources (counters, ALU results, switches) and the display driver.
- Drives the driver's `num` plus a `blank` qualifier. Upstream logic gates segment enables with `blank`.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DWELL, 50000000, cycles the grant is held per window (>=2).
- GAP, 1000, blanking cycles between windows (>=1).
- LIVE, 1, 1 = `num` tracks the owner's value every cycle; 0 = `num` is latched at grant.

Ports:
- clk  in  1  system clock (single clock domain).
- rst  in  1  asynchronous, active-low reset.
- req  in  NREQ  level request per requester.
- value  in  NREQ*12  packed values; requester i occupies bits [12*i+11:12*i].
- num  out  12  value to the display driver.
- owner  out  clog2(NREQ)  index of the current or last grantee.
- grant  out  NREQ  one-hot grant; all zero when not in SHOW.
- done  out  NREQ  one-cycle pulse to the owner when its window completes normally.
- busy  out  1  high in SHOW and GAP.
- blank  out  1  high when the display must be dark (IDLE, GAP).

Behaviour:
- Reset (rst=0, asynchronous, takes effect immediately, including mid-window):
  - state=IDLE, grant=0, done=0, num=0, owner=0.
  - busy=0, blank=1, rr_ptr=0, timer=0.
- Arbitration function: search req circularly starting at rr_ptr (rr_ptr, rr_ptr+1, ... mod NREQ). The first set bit wins.
- States: IDLE, SHOW, GAP. All outputs are registered.
- IDLE:
  - If any req bit is high at a rising edge, that edge loads:
    - state=SHOW, grant=onehot(winner), owner=winner.
    - num=value[winner], timer=0, busy=1, blank=0.
  - Latency: req sampled high at edge k gives grant high after edge k.
- SHOW:
  - timer increments every cycle.
  - If LIVE=1, num follows value[owner] with one register stage. If LIVE=0, num holds.
  - Normal end: timer==DWELL-1 and req[owner]=1. Next edge loads:
    - done[owner]=1 for one cycle, grant=0, blank=1.
    - state=GAP, timer=0, rr_ptr=(owner+1) mod NREQ.
  - grant is therefore high for exactly DWELL cycles.
  - Abort: req[owner]=0 at any edge in SHOW. Next edge goes to GAP with the same updates, except done stays 0. Abort takes priority over the normal end on the same cycle.
  - Requests from other indices during SHOW are ignored until the next arbitration. There is no preemption.
- GAP:
  - blank=1, grant=0, busy=1, num holds its last value. timer counts GAP cycles.
  - When timer==GAP-1:
    - If any req is high, arbitrate directly into SHOW, exactly as from IDLE.
    - Otherwise go to IDLE with busy=0.
- A lone persistent requester is re-granted after each gap. It receives done once per window.
- Width rules:
  - timer width = clog2(max(DWELL,GAP)).
  - Requester values pass unchanged. Values >9999 cannot occur with 12 bits.
- rr_ptr wraps NREQ-1 -> 0.
- grant is always zero or one-hot. done is never asserted while grant is high.

Test Plan (NREQ=4, DWELL=4, GAP=2, LIVE=1):
- Reset behaviour:
  - Stimulus: assert rst=0 mid-SHOW with grant=0010.
  - Required: grant=0, num=0, blank=1, busy=0 immediately, without waiting for a clock edge. After release with no req, the block stays in IDLE.
- Single requester:
  - Stimulus: req=0001, value0=1234 held.
  - Required: grant=0001 after edge 1 for 4 cycles, num=1234, then done[0] pulse, blank for 2 cycles. grant=0001 is re-issued and the pattern repeats.
- Round-robin:
  - Stimulus: req=1111 with values 11, 22, 33, 44.
  - Required: owners are served in order 0,1,2,3,0. Each window is 4 cycles with num equal to that owner's value. done pulses on indices 0,1,2,3 in turn.
- Wrap and skip:
  - Stimulus: rr_ptr=3 with req=0101.
  - Required: owner 0 is granted next, then owner 2. Owners 1 and 3 are never granted.
- Abort:
  - Stimulus: owner 1 drops req on the 2nd SHOW cycle.
  - Required: grant falls on the next edge, done stays 0, a 2-cycle GAP follows, and the next grant goes to index 2 if it is requesting.
- Live update and no preemption:
  - Stimulus: value0 changes 100->200 mid-window.
  - Required: num shows 200 one cycle later.
  - Stimulus: req[3] rises mid-window.
  - Required: grant stays 0001 until the window completes.

Source files
------------

// File: rtl/seg7_display_arbiter_if.sv
// Bus between status requesters and the seven-segment display arbiter.
//   req   : level request per requester
//   value : packed 12-bit values, requester i at [12*i+11:12*i]
//   num   : value presented to the display driver
//   owner : index of the current or last grantee
//   grant : one-hot grant, zero outside the display window
//   done  : one-cycle pulse to the owner when its window completes normally
//   busy  : high while showing or blanking between windows
//   blank : high when the display must be dark
// master = requester/driver side, slave = arbiter side.
interface seg7_display_arbiter_if #(
  parameter int unsigned NREQ = 4
);
  localparam int unsigned OW = $clog2(NREQ);

  logic [NREQ-1:0]    req;
  logic [NREQ*12-1:0] value;
  logic [11:0]        num;
  logic [OW-1:0]      owner;
  logic [NREQ-1:0]    grant;
  logic [NREQ-1:0]    done;
  logic               busy;
  logic               blank;

  modport master (
    output req, value,
    input  num, owner, grant, done, busy, blank
  );

  modport slave (
    input  req, value,
    output num, owner, grant, done, busy, blank
  );
endinterface

// File: rtl/seg7_display_arbiter.sv
// Time-shares one 4-digit seven-segment display among NREQ requesters.
// Round-robin grant, fixed DWELL-cycle display window, GAP-cycle blanking
// gap between windows. All outputs are registered.
//   clk : system clock
//   rst : asynchronous active-low reset
//   bus : seg7_display_arbiter_if slave (req/value in; num/owner/grant/done/busy/blank out)
module seg7_display_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned DWELL = 50000000,
  parameter int unsigned GAP   = 1000,
  parameter int unsigned LIVE  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  seg7_display_arbiter_if.slave bus
);

  localparam int unsigned OW   = $clog2(NREQ);
  localparam int unsigned TMAX = (DWELL > GAP) ? DWELL : GAP;
  localparam int unsigned TW   = $clog2(TMAX);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SHOW = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [NREQ-1:0] done_q, done_d;
  logic [11:0]     num_q, num_d;
  logic [OW-1:0]   owner_q, owner_d;
  logic            busy_q, busy_d;
  logic            blank_q, blank_d;
  logic [OW-1:0]   rr_q, rr_d;
  logic [TW-1:0]   timer_q, timer_d;

  logic            any_req;
  logic            found;
  logic [OW-1:0]   win;
  int unsigned     arb_idx;
  logic [11:0]     win_val;
  logic [11:0]     owner_val;
  logic [OW-1:0]   owner_next;
  logic            start;

  // Circular priority search starting at rr_q; first requesting index wins.
  always_comb begin
    any_req = |bus.req;
    found   = 1'b0;
    win     = rr_q;
    arb_idx = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      arb_idx = 32'(rr_q) + i;
      if (arb_idx >= NREQ) arb_idx = arb_idx - NREQ;
      if (!found && bus.req[OW'(arb_idx)]) begin
        found = 1'b1;
        win   = OW'(arb_idx);
      end
    end
  end

  assign win_val    = bus.value[32'(win)*12 +: 12];
  assign owner_val  = bus.value[32'(owner_q)*12 +: 12];
  assign owner_next = (owner_q == OW'(NREQ - 1)) ? '0 : owner_q + OW'(1);

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    done_d  = '0;
    num_d   = num_q;
    owner_d = owner_q;
    busy_d  = busy_q;
    blank_d = blank_q;
    rr_d    = rr_q;
    timer_d = timer_q;
    start   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (any_req) start = 1'b1;
      end
      ST_SHOW: begin
        timer_d = timer_q + TW'(1);
        if (LIVE != 0) num_d = owner_val;
        // Abort (owner dropped req) and normal end share the exit path;
        // only a normal end pulses done.
        if (!bus.req[owner_q] || (timer_q == TW'(DWELL - 1))) begin
          state_d = ST_GAP;
          grant_d = '0;
          blank_d = 1'b1;
          timer_d = '0;
          rr_d    = owner_next;
          if (bus.req[owner_q]) done_d = grant_q;
        end
      end
      ST_GAP: begin
        timer_d = timer_q + TW'(1);
        if (timer_q == TW'(GAP - 1)) begin
          timer_d = '0;
          if (any_req) begin
            start = 1'b1;
          end else begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Arbitration win, shared by IDLE and end of GAP.
    if (start) begin
      state_d = ST_SHOW;
      grant_d = NREQ'(1) << win;
      owner_d = win;
      num_d   = win_val;
      timer_d = '0;
      busy_d  = 1'b1;
      blank_d = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      done_q  <= '0;
      num_q   <= '0;
      owner_q <= '0;
      busy_q  <= 1'b0;
      blank_q <= 1'b1;
      rr_q    <= '0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      num_q   <= num_d;
      owner_q <= owner_d;
      busy_q  <= busy_d;
      blank_q <= blank_d;
      rr_q    <= rr_d;
      timer_q <= timer_d;
    end
  end

  assign bus.grant = grant_q;
  assign bus.done  = done_q;
  assign bus.num   = num_q;
  assign bus.owner = owner_q;
  assign bus.busy  = busy_q;
  assign bus.blank = blank_q;

endmodule
